// File: rtl/boxcar_line_sequencer.sv
// boxcar_line_sequencer: wraps a boxcar filter with per-line edge padding, warm-up discard and a filter clear
// Ports: clk; reset (async, active low); in_pixel/in_valid/in_last/in_ready come from the source side.
// filt_pixel/filt_valid/filt_reset drive the filter, and filt_avg/filt_avg_valid are its return.
// out_avg/out_valid/out_last go to the consumer and have no backpressure. err_overlong is a sticky flag.
module boxcar_line_sequencer #(
  parameter int RADIUS    = 8,
  parameter int BITS      = 8,
  parameter int MAX_WIDTH = 2048
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] in_pixel,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [BITS-1:0] filt_pixel,
  output logic            filt_valid,
  output logic            filt_reset,
  input  logic [BITS-1:0] filt_avg,
  input  logic            filt_avg_valid,
  output logic [BITS-1:0] out_avg,
  output logic            out_valid,
  output logic            out_last,
  output logic            err_overlong
);
  localparam int CW = $clog2(MAX_WIDTH + 1);
  localparam int RW = $clog2(MAX_WIDTH + 2 * RADIUS + 1);
  localparam int PW = $clog2(RADIUS + 1);
  typedef enum logic [2:0] {IDLE, PAD_L, STREAM, PAD_R, DRAIN, CLEAR} state_t;
  state_t state, state_nx;
  logic [BITS-1:0] edge_pix;
  logic [PW-1:0] pad_cnt;
  logic [CW-1:0] in_cnt, out_cnt;
  logic [RW-1:0] ret_cnt;
  logic rst_hold, beat, pad_done, line_end, keep, padding, tail;
  assign beat     = state == STREAM && in_valid;
  assign padding  = state == PAD_L || state == PAD_R;
  assign tail     = state == PAD_R || state == DRAIN;
  assign pad_done = pad_cnt == PW'(RADIUS - 1);
  assign line_end = in_last || in_cnt == CW'(MAX_WIDTH - 1);
  // The first 2*RADIUS returns come from windows that still contain the left pad warm-up.
  assign keep     = filt_avg_valid && ret_cnt >= RW'(2 * RADIUS);
  // The filter is held clear during reset and on the first cycle after release, so an aborted line leaves nothing behind.
  assign filt_reset = !reset || rst_hold || state == CLEAR;
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    filt_valid = 1'b0;
    filt_pixel = edge_pix;
    case (state)
      IDLE:    if (in_valid) state_nx = PAD_L;
      PAD_L:   begin
        filt_valid = 1'b1;
        if (pad_done) state_nx = STREAM;
      end
      STREAM:  begin
        in_ready   = 1'b1;
        filt_valid = in_valid;
        filt_pixel = in_pixel;
        if (in_valid && line_end) state_nx = PAD_R;
      end
      PAD_R:   begin
        filt_valid = 1'b1;
        if (pad_done) state_nx = DRAIN;
      end
      DRAIN:   if (out_cnt == in_cnt) state_nx = CLEAR;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rst_hold     <= 1'b1;
      edge_pix     <= '0;
      pad_cnt      <= '0;
      in_cnt       <= '0;
      ret_cnt      <= '0;
      out_cnt      <= '0;
      out_avg      <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      err_overlong <= 1'b0;
    end else begin
      rst_hold  <= 1'b0;
      // Latch the line's first pixel while idle and track the newest pixel for the right pad.
      if (in_valid && (state == IDLE || state == STREAM)) edge_pix <= in_pixel;
      pad_cnt   <= padding && !pad_done ? pad_cnt + PW'(1) : '0;
      in_cnt    <= state == CLEAR ? '0 : beat ? in_cnt + CW'(1) : in_cnt;
      ret_cnt   <= state == CLEAR ? '0 : filt_avg_valid ? ret_cnt + RW'(1) : ret_cnt;
      out_cnt   <= state == CLEAR ? '0 : keep ? out_cnt + CW'(1) : out_cnt;
      out_valid <= keep;
      out_last  <= keep && tail && out_cnt + CW'(1) == in_cnt;
      if (keep) out_avg <= filt_avg;
      if (beat && !in_last && in_cnt == CW'(MAX_WIDTH - 1)) err_overlong <= 1'b1;
    end
endmodule
